// File: rtl/pcileech_ft601_rx_unpack_if.sv
// rtl/pcileech_ft601_rx_unpack_if.sv - FT601 RX word input and QWORD FIFO output bundle
interface pcileech_ft601_rx_unpack_if;
    logic [31:0] rx_data;
    logic        rx_wren;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_rd_en;
    logic        almost_full;
    logic        half_pending;
    logic [15:0] ovf_count;
    logic [15:0] orphan_count;

    modport slave (
        input  rx_data, rx_wren, dout_rd_en,
        output dout, dout_valid, almost_full, half_pending, ovf_count, orphan_count
    );

    modport master (
        output rx_data, rx_wren, dout_rd_en,
        input  dout, dout_valid, almost_full, half_pending, ovf_count, orphan_count
    );
endinterface

// File: rtl/pcileech_ft601_rx_unpack.sv
// rtl/pcileech_ft601_rx_unpack.sv - pairs FT601 DWORDs into command QWORDs behind a FWFT FIFO
module pcileech_ft601_rx_unpack #(
    parameter int unsigned PARAM_DEPTH_LOG2   = 4,
    parameter int unsigned PARAM_AFULL_MARGIN = 4,
    parameter int unsigned PARAM_TIMEOUT      = 1023,
    parameter logic [31:0] PARAM_MAGIC        = 32'h66665555
) (
    input  logic                         clk,
    input  logic                         rst,
    pcileech_ft601_rx_unpack_if.slave    bus
);

    localparam int unsigned DEPTH = 1 << PARAM_DEPTH_LOG2;
    localparam int unsigned CW    = PARAM_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [15:0]   TIMEOUT_LAST = 16'(PARAM_TIMEOUT - 1);

    typedef enum logic {ST_LO, ST_HI} state_t;

    state_t      state_q;
    logic [31:0] low_q;
    logic [15:0] timer_q;
    logic [15:0] orphan_q;

    logic [63:0]                 mem_q [DEPTH];
    logic [PARAM_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [PARAM_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [CW-1:0]               free_d;
    logic [15:0]                 ovf_q, ovf_d;
    logic                        afull_q;

    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        full;
    logic [63:0] push_qw;

    // Padding is only recognised in LO; in HI any value is payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LO;
            low_q    <= '0;
            timer_q  <= '0;
            orphan_q <= '0;
        end else begin
            case (state_q)
                ST_LO: begin
                    if (bus.rx_wren && (bus.rx_data != PARAM_MAGIC)) begin
                        low_q   <= bus.rx_data;
                        timer_q <= '0;
                        state_q <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (bus.rx_wren) begin
                        state_q <= ST_LO;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        state_q <= ST_LO;
                        if (orphan_q != 16'hFFFF) begin
                            orphan_q <= orphan_q + 16'd1;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign push_req = (state_q == ST_HI) && bus.rx_wren;
    assign push_qw  = {bus.rx_data, low_q};
    assign pop      = bus.dout_rd_en && (count_q != '0);
    assign full     = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_req && !push_ok && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop);
        free_d  = DEPTH_C - count_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            afull_q  <= (32'(free_d) <= 32'(PARAM_AFULL_MARGIN));
        end
    end

    // Storage is not reset; reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_qw;
        end
    end

    assign bus.dout         = (count_q != '0) ? mem_q[rd_ptr_q] : 64'd0;
    assign bus.dout_valid   = (count_q != '0);
    assign bus.almost_full  = afull_q;
    assign bus.half_pending = (state_q == ST_HI);
    assign bus.ovf_count    = ovf_q;
    assign bus.orphan_count = orphan_q;

endmodule

// File: tb/tb_pcileech_ft601_rx_unpack.sv
// tb/tb_pcileech_ft601_rx_unpack.sv - directed self-checking bench for pcileech_ft601_rx_unpack
module tb_pcileech_ft601_rx_unpack;

    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pcileech_ft601_rx_unpack_if bus ();

    pcileech_ft601_rx_unpack #(
        .PARAM_DEPTH_LOG2   (4),
        .PARAM_AFULL_MARGIN (4),
        .PARAM_TIMEOUT      (TIMEOUT),
        .PARAM_MAGIC        (32'h66665555)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put_dw(input logic [31:0] dw, input logic rd);
        bus.rx_data    = dw;
        bus.rx_wren    = 1'b1;
        bus.dout_rd_en = rd;
        @(negedge clk);
        bus.rx_wren    = 1'b0;
        bus.rx_data    = 32'd0;
        bus.dout_rd_en = 1'b0;
    endtask

    task automatic pop_one();
        bus.dout_rd_en = 1'b1;
        @(negedge clk);
        bus.dout_rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout"},   bus.dout, 64'd0);
        chk({tag, "_valid"},  {63'd0, bus.dout_valid}, 64'd0);
        chk({tag, "_afull"},  {63'd0, bus.almost_full}, 64'd0);
        chk({tag, "_half"},   {63'd0, bus.half_pending}, 64'd0);
        chk({tag, "_ovf"},    {48'd0, bus.ovf_count}, 64'd0);
        chk({tag, "_orphan"}, {48'd0, bus.orphan_count}, 64'd0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.rx_data    = 32'd0;
        bus.rx_wren    = 1'b0;
        bus.dout_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // 1: basic pairing, low DWORD first
        put_dw(32'h11111111, 1'b0);
        chk("t1_half_set", {63'd0, bus.half_pending}, 64'd1);
        chk("t1_not_yet_valid", {63'd0, bus.dout_valid}, 64'd0);
        put_dw(32'h22222222, 1'b0);
        chk("t1_valid", {63'd0, bus.dout_valid}, 64'd1);
        chk("t1_dout", bus.dout, 64'h22222222_11111111);
        chk("t1_half_clr", {63'd0, bus.half_pending}, 64'd0);
        pop_one();
        chk("t1_empty", {63'd0, bus.dout_valid}, 64'd0);

        // 2: padding dropped on QWORD boundary
        repeat (5) put_dw(32'h66665555, 1'b0);
        chk("t2_pad_no_half", {63'd0, bus.half_pending}, 64'd0);
        chk("t2_pad_no_valid", {63'd0, bus.dout_valid}, 64'd0);
        put_dw(32'hAAAAAAAA, 1'b0);
        put_dw(32'hBBBBBBBB, 1'b0);
        chk("t2_dout", bus.dout, 64'hBBBBBBBB_AAAAAAAA);
        pop_one();
        chk("t2_single", {63'd0, bus.dout_valid}, 64'd0);
        chk("t2_ovf", {48'd0, bus.ovf_count}, 64'd0);
        chk("t2_orphan", {48'd0, bus.orphan_count}, 64'd0);

        // 3: magic kept as high half
        put_dw(32'h12345678, 1'b0);
        put_dw(32'h66665555, 1'b0);
        chk("t3_dout", bus.dout, 64'h66665555_12345678);
        pop_one();

        // 4: timeout boundary
        put_dw(32'hCAFEF00D, 1'b0);
        idle(TIMEOUT - 1);
        chk("t4_half_before", {63'd0, bus.half_pending}, 64'd1);
        idle(1);
        chk("t4_half_after", {63'd0, bus.half_pending}, 64'd0);
        chk("t4_orphan", {48'd0, bus.orphan_count}, 64'd1);
        chk("t4_no_qword", {63'd0, bus.dout_valid}, 64'd0);

        // 4b: completion on the timeout cycle wins
        put_dw(32'hDEAD0001, 1'b0);
        idle(TIMEOUT - 1);
        put_dw(32'hDEAD0002, 1'b0);
        chk("t4b_dout", bus.dout, 64'hDEAD0002_DEAD0001);
        chk("t4b_orphan", {48'd0, bus.orphan_count}, 64'd1);
        chk("t4b_half", {63'd0, bus.half_pending}, 64'd0);
        pop_one();

        // 5: fill beyond depth, almost_full threshold, overflow count
        for (int i = 0; i < DEPTH + 2; i++) begin
            put_dw(32'h10000000 + 32'(i), 1'b0);
            put_dw(32'h20000000 + 32'(i), 1'b0);
            if (i == 10) chk("t5_afull_at11", {63'd0, bus.almost_full}, 64'd0);
            if (i == 11) chk("t5_afull_at12", {63'd0, bus.almost_full}, 64'd1);
        end
        chk("t5_ovf", {48'd0, bus.ovf_count}, 64'd2);
        chk("t5_afull_full", {63'd0, bus.almost_full}, 64'd1);
        chk("t5_head", bus.dout, 64'h20000000_10000000);

        // push while full with simultaneous pop is accepted
        put_dw(32'h30000000, 1'b0);
        put_dw(32'h40000000, 1'b1);
        chk("t5_pushpop_ovf", {48'd0, bus.ovf_count}, 64'd2);
        chk("t5_pushpop_head", bus.dout, 64'h20000001_10000001);

        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("t5_drain_%0d", i), bus.dout,
                {32'h20000000 + 32'(i), 32'h10000000 + 32'(i)});
            pop_one();
        end
        chk("t5_drain_last", bus.dout, 64'h40000000_30000000);
        pop_one();
        chk("t5_drained", {63'd0, bus.dout_valid}, 64'd0);
        chk("t5_afull_clr", {63'd0, bus.almost_full}, 64'd0);

        // 6: reset mid-QWORD with FIFO half full
        for (int i = 0; i < DEPTH / 2; i++) begin
            put_dw(32'h50000000 + 32'(i), 1'b0);
            put_dw(32'h60000000 + 32'(i), 1'b0);
        end
        put_dw(32'h5A5A5A5A, 1'b0);
        chk("t6_pre_half", {63'd0, bus.half_pending}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("t6_rst");
        put_dw(32'h77777777, 1'b0);
        put_dw(32'h88888888, 1'b0);
        chk("t6_new_qword", bus.dout, 64'h88888888_77777777);
        pop_one();
        chk("t6_only_one", {63'd0, bus.dout_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
